// File: rtl/som_bmu_scheduler.sv
// SOM best-matching-unit search: reduces 8-lane batches with a min tree and keeps a running winner over NUM_GROUPS batches.
// Optional BMU_ZERO_EXIT_EN: finish early when a batch minimum of zero is accepted.
module som_bmu_scheduler #(
  parameter int NUM_GROUPS = 8,
  parameter int DW         = 11,
  parameter int WW         = 24,
  parameter int IW         = $clog2(8*NUM_GROUPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] d_bus,
  input  logic [8*WW-1:0] w_bus,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   bmu_dist,
  output logic [IW-1:0]   bmu_index,
  output logic [WW-1:0]   bmu_weight
);

  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] grp_cnt;

  logic [DW-1:0] ln_d  [8];
  logic [WW-1:0] ln_w  [8];
  logic [DW-1:0] l1_d  [4];
  logic [WW-1:0] l1_w  [4];
  logic [2:0]    l1_l  [4];
  logic [DW-1:0] l2_d  [2];
  logic [WW-1:0] l2_w  [2];
  logic [2:0]    l2_l  [2];
  logic [DW-1:0] t_d;
  logic [WW-1:0] t_w;
  logic [2:0]    t_l;

  logic          accept;
  logic          last_grp;
  logic          first_grp;
  logic          win;
  logic          zero_exit;
  logic [GW+2:0] idx_full;

  // Left operand wins only when strictly smaller, so ties go to the higher lane.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ln_d[i] = d_bus[i*DW +: DW];
      ln_w[i] = w_bus[i*WW +: WW];
    end
    for (int i = 0; i < 4; i++) begin
      if (ln_d[2*i] < ln_d[2*i+1]) begin
        l1_d[i] = ln_d[2*i];
        l1_w[i] = ln_w[2*i];
        l1_l[i] = 3'(2*i);
      end else begin
        l1_d[i] = ln_d[2*i+1];
        l1_w[i] = ln_w[2*i+1];
        l1_l[i] = 3'(2*i+1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (l1_d[2*i] < l1_d[2*i+1]) begin
        l2_d[i] = l1_d[2*i];
        l2_w[i] = l1_w[2*i];
        l2_l[i] = l1_l[2*i];
      end else begin
        l2_d[i] = l1_d[2*i+1];
        l2_w[i] = l1_w[2*i+1];
        l2_l[i] = l1_l[2*i+1];
      end
    end
    if (l2_d[0] < l2_d[1]) begin
      t_d = l2_d[0];
      t_w = l2_w[0];
      t_l = l2_l[0];
    end else begin
      t_d = l2_d[1];
      t_w = l2_w[1];
      t_l = l2_l[1];
    end
  end

  assign in_ready  = (state == S_COLLECT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = in_valid & in_ready;
  assign last_grp  = (grp_cnt == GW'(NUM_GROUPS-1));
  assign first_grp = (grp_cnt == '0);
  // Later batches must be strictly better, so the earliest group keeps a tie.
  assign win       = first_grp | (t_d < bmu_dist);
  assign idx_full  = {grp_cnt, t_l};

`ifdef BMU_ZERO_EXIT_EN
  assign zero_exit = (t_d == '0);
`else
  assign zero_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grp_cnt    <= '0;
      bmu_dist   <= '0;
      bmu_index  <= '0;
      bmu_weight <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_COLLECT;
            grp_cnt <= '0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            grp_cnt <= grp_cnt + 1'b1;
            if (win) begin
              bmu_dist   <= t_d;
              bmu_index  <= idx_full[IW-1:0];
              bmu_weight <= t_w;
            end
            if (last_grp || zero_exit) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_som_bmu_scheduler.sv
// Scoreboard bench for som_bmu_scheduler: driver queues expected BMU results, monitor checks them on done.
module tb_som_bmu_scheduler;
  localparam int NG = 8;
  localparam int DW = 11;
  localparam int WW = 24;
  localparam int IW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [8*DW-1:0] d_bus = '0;
  logic [8*WW-1:0] w_bus = '0;
  logic            busy;
  logic            done;
  logic [DW-1:0]   bmu_dist;
  logic [IW-1:0]   bmu_index;
  logic [WW-1:0]   bmu_weight;

  som_bmu_scheduler #(.NUM_GROUPS(NG), .DW(DW), .WW(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .d_bus(d_bus), .w_bus(w_bus), .busy(busy), .done(done),
    .bmu_dist(bmu_dist), .bmu_index(bmu_index), .bmu_weight(bmu_weight)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic [WW-1:0] w;
  } exp_t;

  exp_t          q[$];
  int            n_vec = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            last_done_cyc = 0;
  logic [DW-1:0] dist_t [NG][8];
  logic [WW-1:0] wt_t   [NG][8];
  exp_t          held = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      last_done_cyc = cyc;
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: done seen with no search pending (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("bmu_dist", 64'(bmu_dist), 64'(e.d));
        chk("bmu_index", 64'(bmu_index), 64'(e.i));
        chk("bmu_weight", 64'(bmu_weight), 64'(e.w));
      end
    end
  end

  task automatic fill_default();
    for (int g = 0; g < NG; g++)
      for (int l = 0; l < 8; l++) begin
        dist_t[g][l] = 11'd100;
        wt_t[g][l]   = 24'(g * 24'h010000 + l);
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_bmu_dist"}, 64'(bmu_dist), 64'd0);
    chk({tag, "_bmu_index"}, 64'(bmu_index), 64'd0);
    chk({tag, "_bmu_weight"}, 64'(bmu_weight), 64'd0);
  endtask

  // vmode 0: in_valid held high; vmode 1: in_valid 1,0,0,... plus a stray start.
  task automatic run_search(input string tag, input int vmode, input int abort_after,
                            input exp_t e, input int exp_acc, input bit chk_lat);
    int acc, t, s_cyc, dc0;
    bit took;
    dc0 = done_cnt;
    if (abort_after == 0) q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    chk({tag, "_rdy_after_start"}, 64'(in_ready), 64'd1);
    chk({tag, "_hold_dist"}, 64'(bmu_dist), 64'(held.d));
    chk({tag, "_hold_index"}, 64'(bmu_index), 64'(held.i));
    acc = 0;
    t = 0;
    while (acc < NG && t < 200) begin
      for (int l = 0; l < 8; l++) begin
        d_bus[l*DW +: DW] = dist_t[acc][l];
        w_bus[l*WW +: WW] = wt_t[acc][l];
      end
      in_valid = (vmode == 0) ? 1'b1 : (t % 3 == 0);
      start    = (vmode == 1 && t == 4);
      took     = in_valid && in_ready;
      @(posedge clk); #1;
      t++;
      if (took) acc++;
      if (abort_after > 0 && acc == abort_after) break;
      if (!in_ready) break;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (abort_after > 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs({tag, "_abort"});
      repeat (12) @(negedge clk);
      chk({tag, "_no_done_after_abort"}, 64'(done_cnt), 64'(dc0));
      held = '0;
    end else begin
      for (int k = 0; k < 20 && done_cnt == dc0; k++) @(negedge clk);
      chk({tag, "_accepts"}, 64'(acc), 64'(exp_acc));
      if (chk_lat) chk({tag, "_done_latency"}, 64'(last_done_cyc - s_cyc), 64'(exp_acc + 1));
      repeat (4) @(negedge clk);
      chk({tag, "_done_once"}, 64'(done_cnt), 64'(dc0 + 1));
      chk({tag, "_rdy_after_done"}, 64'(in_ready), 64'd0);
      held = e;
    end
  endtask

  initial begin
    exp_t e;
    int zacc;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    fill_default();
    dist_t[5][3] = 11'd7;
    wt_t[5][3]   = 24'hABCDEF;
    e = '{d: 11'd7, i: 6'd43, w: 24'hABCDEF};
    run_search("last_grp_winner", 0, 0, e, 8, 1'b1);

    fill_default();
    dist_t[0][2] = 11'd5;
    dist_t[0][6] = 11'd5;
    e = '{d: 11'd5, i: 6'd6, w: 24'h000006};
    run_search("tie_in_batch", 0, 0, e, 8, 1'b1);

    fill_default();
    dist_t[1][0] = 11'd5;
    dist_t[4][0] = 11'd5;
    e = '{d: 11'd5, i: 6'd8, w: 24'h010000};
    run_search("tie_across", 0, 0, e, 8, 1'b1);

    fill_default();
    dist_t[7][7] = 11'd1;
    e = '{d: 11'd1, i: 6'd63, w: 24'h070007};
    run_search("backpressure", 1, 0, e, 8, 1'b0);

    fill_default();
    dist_t[1][1] = 11'd2;
    run_search("abort", 0, 3, e, 3, 1'b0);

    fill_default();
    dist_t[2][4] = 11'd3;
    dist_t[6][1] = 11'd3;
    e = '{d: 11'd3, i: 6'd20, w: 24'h020004};
    run_search("after_abort", 0, 0, e, 8, 1'b1);

`ifdef BMU_ZERO_EXIT_EN
    zacc = 3;
`else
    zacc = 8;
`endif
    fill_default();
    dist_t[2][1] = 11'd0;
    e = '{d: 11'd0, i: 6'd17, w: 24'h020001};
    run_search("zero_exit", 0, 0, e, zacc, 1'b1);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
